// File: rtl/dmem_ctrl_pkg.sv
// Shared types, defaults and the byte-merge helper for the data-memory controller.
package dmem_ctrl_pkg;

  localparam int unsigned DMEM_DEPTH_DEF = 128;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BE_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } dmem_state_t;

  // Byte lane i comes from new_word when be[i] is set, otherwise from old_word.
  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_word,
                                                    input logic [WORD_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way arbiter: round-robin by default, fixed priority (port 0 first)
// when DMEM_CTRL_FIXED_PRIO_EN is defined.
module dmem_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef DMEM_CTRL_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, rst, adv};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  logic last;

  // On contention, the port not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last <= 1'b1;
    else if (adv) last <= gnt[1];
  end
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Shares a single-port word memory between two requesters with bounds checking
// and read-modify-write sub-word stores. DMEM_CTRL_FIXED_PRIO_EN selects fixed priority.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic        rerr,
  output logic [31:0] rdata,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = 30;

  dmem_state_t state, next_state;

  logic [1:0]        arb_gnt;
  logic              take;
  logic              sel;
  logic              we_w;
  logic [31:0]       addr_w;
  logic [31:0]       wdata_w;
  logic [3:0]        be_w;
  logic              oob;

  logic              own_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_w[1:0];

  assign take = (state == ST_IDLE) && (|req);

  dmem_rr_arbiter u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (take),
    .gnt (arb_gnt)
  );

  // Winner's request fields, only meaningful while take is high.
  assign sel     = arb_gnt[1];
  assign we_w    = sel ? we[1]  : we[0];
  assign addr_w  = sel ? addr1  : addr0;
  assign wdata_w = sel ? wdata1 : wdata0;
  assign be_w    = sel ? be1    : be0;
  assign oob     = addr_w[31:2] >= IDX_W'(DEPTH);

  assign gnt = (state == ST_IDLE) ? arb_gnt : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          if (oob)                          next_state = ST_RESP;
          else if (we_w && be_w == 4'h0)    next_state = ST_RESP;
          else if (!we_w || be_w == 4'hF)   next_state = ST_ACCESS;
          else                              next_state = ST_RMW_RD;
        end
      end
      ST_ACCESS: next_state = ST_RESP;
      ST_RMW_RD: next_state = ST_RMW_WR;
      ST_RMW_WR: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Transaction capture and read-data / merge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (take) begin
        own_q   <= sel;
        we_q    <= we_w;
        idx_q   <= addr_w[31:2];
        wdata_q <= wdata_w;
        be_q    <= be_w;
        err_q   <= oob;
        rdata_q <= '0;
      end
      if (state == ST_ACCESS && !we_q) rdata_q <= mem_rdata;
      if (state == ST_RMW_RD)          merge_q <= mem_rdata;
    end
  end

  // Memory and response outputs decode from state and latched registers only.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    mem_addr  = (state == ST_IDLE) ? 32'h0 : {2'b00, idx_q};
    rvalid    = 2'b00;
    rerr      = 1'b0;
    rdata     = '0;
    unique case (state)
      ST_ACCESS: begin
        mem_rd_en = !we_q;
        mem_wr_en = we_q;
        if (we_q) mem_wdata = wdata_q;
      end
      ST_RMW_RD: mem_rd_en = 1'b1;
      ST_RMW_WR: begin
        mem_wr_en = 1'b1;
        mem_wdata = merge_bytes(merge_q, wdata_q, be_q);
      end
      ST_RESP: begin
        rvalid = own_q ? 2'b10 : 2'b01;
        rerr   = err_q;
        rdata  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
